// File: rtl/vec_stream_engine.sv
// Stimulus/response engine for combinational benchmark aging runs: applies a table
// of input vectors at a programmable settle interval, checks and MISR-compacts responses.
module vec_stream_engine #(
  parameter int               IN_W  = 41,
  parameter int               OUT_W = 32,
  parameter int               DEPTH = 8,
  parameter int               AW    = $clog2(DEPTH),
  parameter int               SW    = 8,
  parameter int               CW    = 16,
  parameter logic [OUT_W-1:0] POLY  = 32'h04C11DB7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [IN_W-1:0]  ld_vec,
  input  logic [OUT_W-1:0] ld_exp,
  input  logic [OUT_W-1:0] ld_mask,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [AW:0]      num_vec,
  input  logic [SW-1:0]    settle,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             cap_valid,
  output logic [OUT_W-1:0] cap_data,
  output logic [AW-1:0]    cap_idx,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    pass_cnt,
  output logic [OUT_W-1:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [IN_W-1:0]  vec_mem  [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];
  logic [OUT_W-1:0] mask_mem [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      num_q, num_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    period_q, period_d;
  logic             loop_q, loop_d;
  logic             fin_q, fin_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic             cap_valid_q, cap_valid_d;
  logic [OUT_W-1:0] cap_data_q, cap_data_d;
  logic [AW-1:0]    cap_idx_q, cap_idx_d;
  logic [CW-1:0]    err_q, err_d;
  logic [CW-1:0]    pass_q, pass_d;
  logic [OUT_W-1:0] sig_q, sig_d;

  logic [AW-1:0]    idx_inc;
  logic [AW:0]      last_idx;
  logic [SW-1:0]    settle_m1;
  logic [AW:0]      num_clamp;
  logic             miss;

  // Table is write-only from the load port and never reset.
  always_ff @(posedge clk) begin
    if (ld_we && (state_q != S_RUN) && ({1'b0, ld_addr} < DEPTH_V)) begin
      vec_mem[ld_addr]  <= ld_vec;
      exp_mem[ld_addr]  <= ld_exp;
      mask_mem[ld_addr] <= ld_mask;
    end
  end

  assign idx_inc   = idx_q + 1'b1;
  assign last_idx  = num_q - 1'b1;
  assign settle_m1 = (settle == '0) ? '0 : settle - 1'b1;
  assign num_clamp = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
  assign miss      = |((dut_out ^ exp_mem[idx_q]) & mask_mem[idx_q]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    loop_d      = loop_q;
    fin_d       = fin_q;
    dut_in_d    = dut_in_q;
    cap_valid_d = 1'b0;
    cap_data_d  = cap_data_q;
    cap_idx_d   = cap_idx_q;
    err_d       = err_q;
    pass_d      = pass_q;
    sig_d       = sig_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d  = '0;
          pass_d = '0;
          sig_d  = '0;
          if (num_vec == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            loop_d   = loop_en;
            num_d    = num_clamp;
            period_d = settle_m1;
            cnt_d    = settle_m1;
            idx_d    = '0;
            fin_d    = 1'b0;
            dut_in_d = vec_mem[0];
          end
        end
      end
      S_RUN: begin
        // fin_q marks the cycle between the final sample and DONE.
        if (stop) begin
          state_d = S_IDLE;
        end else if (fin_q) begin
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          cap_valid_d = 1'b1;
          cap_data_d  = dut_out;
          cap_idx_d   = idx_q;
          if (miss && (err_q != '1)) err_d = err_q + 1'b1;
          sig_d = {sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? POLY : '0) ^ dut_out;
          cnt_d = period_q;
          if ({1'b0, idx_q} == last_idx) begin
            if (pass_q != '1) pass_d = pass_q + 1'b1;
            if (loop_q) begin
              idx_d    = '0;
              dut_in_d = vec_mem[0];
            end else begin
              fin_d = 1'b1;
            end
          end else begin
            idx_d    = idx_inc;
            dut_in_d = vec_mem[idx_inc];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      period_q    <= '0;
      loop_q      <= 1'b0;
      fin_q       <= 1'b0;
      dut_in_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_idx_q   <= '0;
      err_q       <= '0;
      pass_q      <= '0;
      sig_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      loop_q      <= loop_d;
      fin_q       <= fin_d;
      dut_in_q    <= dut_in_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_idx_q   <= cap_idx_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      sig_q       <= sig_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dut_in    = dut_in_q;
  assign cap_valid = cap_valid_q;
  assign cap_data  = cap_data_q;
  assign cap_idx   = cap_idx_q;
  assign err_cnt   = err_q;
  assign pass_cnt  = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_vec_stream_engine.sv
// Bench for vec_stream_engine: a combinational stand-in circuit, a timing-formula model
// checked every cycle by a negedge monitor, plus directed runs with literal expectations.
module tb_vec_stream_engine;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk, rst;
  logic        ld_we;
  logic [2:0]  ld_addr;
  logic [40:0] ld_vec;
  logic [31:0] ld_exp, ld_mask;
  logic        start, stop, loop_en;
  logic [3:0]  num_vec;
  logic [7:0]  settle;
  logic [40:0] dut_in;
  logic [31:0] dut_out;
  logic        busy, done, cap_valid;
  logic [31:0] cap_data;
  logic [2:0]  cap_idx;
  logic [15:0] err_cnt, pass_cnt;
  logic [31:0] signature;

  vec_stream_engine dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_vec(ld_vec),
    .ld_exp(ld_exp), .ld_mask(ld_mask), .start(start), .stop(stop), .loop_en(loop_en),
    .num_vec(num_vec), .settle(settle), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .cap_valid(cap_valid), .cap_data(cap_data),
    .cap_idx(cap_idx), .err_cnt(err_cnt), .pass_cnt(pass_cnt), .signature(signature)
  );

  // Stand-in circuit: identity on the low 32 bits when the top 9 input bits are zero.
  function automatic logic [31:0] cut(input logic [40:0] v);
    return v[31:0] ^ {v[40:32], 14'h0, v[40:32]};
  endfunction

  always_comb dut_out = cut(dut_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Bench copy of the table and model state.
  logic [40:0] t_vec  [8];
  logic [31:0] t_exp  [8];
  logic [31:0] t_mask [8];
  bit          m_on = 1'b0;
  bit          m_loop;
  int          m_k0, m_S, m_N, cap_seen;
  logic [15:0] m_err, m_pass;
  logic [31:0] m_sig, sig_ref;

  always @(negedge clk) begin : mon
    int t, ix, vi;
    logic [31:0] o;
    logic smp;
    if (m_on) begin
      t   = cyc - m_k0;
      smp = (t >= 1) && (t % m_S == 0) && (m_loop || (t / m_S) <= m_N);
      if (m_loop || (t / m_S) < m_N) vi = (t / m_S) % m_N;
      else vi = m_N - 1;
      chk("dut_in", dut_in, t_vec[vi]);
      chk("busy", busy, m_loop || t <= m_N * m_S);
      chk("done", done, !m_loop && t > m_N * m_S);
      chk("cap_valid", cap_valid, smp);
      if (cap_valid === 1'b1) cap_seen++;
      if (smp) begin
        ix = (t / m_S - 1) % m_N;
        o  = cut(t_vec[ix]);
        if ((((o ^ t_exp[ix]) & t_mask[ix]) != 0) && m_err != 16'hFFFF) m_err++;
        m_sig = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? POLY : 32'h0) ^ o;
        if (ix == m_N - 1 && m_pass != 16'hFFFF) m_pass++;
        chk("cap_idx", cap_idx, ix);
        chk("cap_data", cap_data, o);
      end else begin
        chk("err_cnt", err_cnt, m_err);
        chk("pass_cnt", pass_cnt, m_pass);
        chk("signature", signature, m_sig);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int a, input logic [40:0] v, input logic [31:0] e, input logic [31:0] m);
    ld_we = 1'b1; ld_addr = 3'(a); ld_vec = v; ld_exp = e; ld_mask = m;
    tick();
    ld_we = 1'b0;
    t_vec[a] = v; t_exp[a] = e; t_mask[a] = m;
  endtask

  task automatic run_start(input int n, input int s, input bit lp);
    num_vec = 4'(n); settle = 8'(s); loop_en = lp; start = 1'b1;
    tick();
    start = 1'b0;
    m_k0 = cyc; m_S = (s == 0) ? 1 : s; m_N = n; m_loop = lp;
    m_err = '0; m_pass = '0; m_sig = '0; cap_seen = 0;
    m_on = (n != 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " cap_valid"}, cap_valid, 0);
    chk({tag, " cap_data"}, cap_data, 0);
    chk({tag, " cap_idx"}, cap_idx, 0);
    chk({tag, " err_cnt"}, err_cnt, 0);
    chk({tag, " pass_cnt"}, pass_cnt, 0);
    chk({tag, " signature"}, signature, 0);
    chk({tag, " dut_in"}, dut_in, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ld_we = 0; ld_addr = 0; ld_vec = 0; ld_exp = 0; ld_mask = 0;
    start = 0; stop = 0; loop_en = 0; num_vec = 0; settle = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("post-reset");

    // Single pass, all match, settle 3.
    for (int i = 0; i < 8; i++) begin
      logic [40:0] v;
      v = 41'(64'h9E3779B97F4A7C15 * (i + 1));
      load(i, v, cut(v), 32'hFFFF_FFFF);
    end
    run_start(8, 3, 0);
    repeat (2) tick();
    ld_we = 1'b1; ld_addr = 3'd7; ld_vec = 41'h155_5555_5555; ld_exp = 0; ld_mask = 0;
    tick();
    ld_we = 1'b0;
    repeat (21) tick();
    chk("t1 done@24", done, 0);
    tick();
    chk("t1 done@25", done, 1);
    chk("t1 err_cnt", err_cnt, 0);
    chk("t1 pass_cnt", pass_cnt, 1);
    chk("t1 cap pulses", cap_seen, 8);
    sig_ref = m_sig;
    m_on = 1'b0;

    // Masked mismatch on entry 2 bit 5.
    load(2, t_vec[2], cut(t_vec[2]) ^ 32'h20, 32'hFFFF_FFFF);
    run_start(3, 2, 0);
    repeat (8) tick();
    chk("mask1 err_cnt", err_cnt, 1);
    m_on = 1'b0;
    load(2, t_vec[2], t_exp[2], ~32'h20);
    run_start(3, 2, 0);
    repeat (8) tick();
    chk("mask0 err_cnt", err_cnt, 0);
    m_on = 1'b0;

    // Loop mode, then stop.
    run_start(3, 1, 1);
    repeat (30) tick();
    chk("loop pass_cnt@stop", pass_cnt, 10);
    chk("loop busy@stop", busy, 1);
    stop = 1'b1;
    tick();
    m_on = 1'b0;
    stop = 1'b0;
    chk("stop busy", busy, 0);
    chk("stop done", done, 0);
    chk("stop cap_valid", cap_valid, 0);
    chk("stop pass_cnt", pass_cnt, 10);
    chk("stop signature", signature, m_sig);

    // Zero vectors.
    run_start(0, 3, 0);
    chk("nv0 done", done, 1);
    chk("nv0 busy", busy, 0);
    chk("nv0 pass_cnt", pass_cnt, 0);
    chk("nv0 signature", signature, 0);
    for (int i = 0; i < 3; i++) begin
      chk("nv0 cap_valid", cap_valid, 0);
      tick();
    end

    // settle 0 acts as settle 1.
    run_start(4, 0, 0);
    repeat (4) tick();
    chk("s0 done@4", done, 0);
    tick();
    chk("s0 done@5", done, 1);
    chk("s0 pass_cnt", pass_cnt, 1);
    m_on = 1'b0;

    // Async reset between edges, then restart.
    run_start(8, 3, 0);
    repeat (10) tick();
    m_on = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk_zero("async");
    tick();
    rst = 1'b0;
    run_start(8, 3, 0);
    repeat (25) tick();
    chk("restart done", done, 1);
    chk("restart signature", signature, sig_ref);
    m_on = 1'b0;

    // Hand-computed MISR: 1, 80000000, 0 -> 2 ^ 80000000 -> shift ^ POLY.
    load(0, 41'h0_0000_0001, 32'h0000_0001, 32'hFFFF_FFFF);
    load(1, 41'h0_8000_0000, 32'h8000_0000, 32'hFFFF_FFFF);
    load(2, 41'h0_0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
    run_start(3, 2, 0);
    repeat (7) tick();
    chk("pin done", done, 1);
    chk("pin signature", signature, 32'h04C1_1DB3);
    chk("pin err_cnt", err_cnt, 0);
    m_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_stream_engine.md
# vec_stream_engine

Synthesizable stimulus/response engine that replaces the behavioural vector-file fixtures used around the ISCAS'85 combinational benchmarks (c499 and siblings) in the aging experiments. It holds a programmable table of input vectors and expected responses and applies them to a combinational DUT at a programmable settle interval. It captures every response, counts masked mismatches and compacts all responses into a MISR signature. It supports single-pass and continuous-loop modes for long aging stress runs.

## Interface
- `IN_W`, 41: DUT input vector width (bit IN_W-1 drives the first primary input).
- `OUT_W`, 32: DUT output vector width; also the MISR width.
- `DEPTH`, 8: vector table entries.
- `AW`, $clog2(DEPTH): table address width.
- `SW`, 8: settle counter width.
- `CW`, 16: error and pass counter width.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial, OUT_W bits.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ld_we` in 1: table write strobe; ignored while `busy`.
- `ld_addr` in AW: table write address.
- `ld_vec` in IN_W: input vector to store.
- `ld_exp` in OUT_W: expected response to store.
- `ld_mask` in OUT_W: compare mask to store; 1 = bit checked.
- `start` in 1: begin run; sampled only in IDLE or DONE.
- `stop` in 1: abort run.
- `loop_en` in 1: 0 = single pass; 1 = wrap and repeat. Sampled at `start`.
- `num_vec` in AW+1: vectors per pass (0..DEPTH). Sampled at `start`.
- `settle` in SW: cycles each vector is held before sampling; 0 is treated as 1. Sampled at `start`.
- `dut_in` out IN_W: drives DUT inputs.
- `dut_out` in OUT_W: DUT outputs.
- `busy` out 1: run in progress.
- `done` out 1: pass completed; level output.
- `cap_valid` out 1: one-cycle pulse per sampled response.
- `cap_data` out OUT_W: captured response.
- `cap_idx` out AW: table index of the captured response.
- `err_cnt` out CW: saturating count of mismatching vectors.
- `pass_cnt` out CW: saturating count of completed passes.
- `signature` out OUT_W: MISR value.

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **Reset values:** all outputs are 0. The table contents are not reset.
- **Table writes:** on `ld_we` and not `busy`, `ld_vec`, `ld_exp` and `ld_mask` are written at `ld_addr`. An out-of-range address is ignored.
- **Start, IDLE/DONE → RUN:** `start` with `num_vec` ≠ 0 does the following on the next edge:
  - latches `loop_en`, `num_vec` and `settle`;
  - sets idx = 0 and `dut_in` = vec[0];
  - loads the settle counter;
  - clears `err_cnt`, `pass_cnt` and `signature`;
  - sets `busy` = 1 and `done` = 0.
- **Start with zero vectors:** `start` with `num_vec` = 0 goes straight to DONE with `done` = 1 and all counters cleared.
- **Sample edge (RUN):** the settle counter reaches its last cycle after the vector has been held `settle` cycles. On that edge:
  - `cap_data` ← `dut_out`, `cap_idx` ← idx, and `cap_valid` is pulsed;
  - if ((`dut_out` ^ exp[idx]) & mask[idx]) ≠ 0, `err_cnt` increments, saturating at 2^CW−1;
  - signature ← {signature[OUT_W-2:0], 0} ^ (signature[OUT_W-1] ? POLY : 0) ^ `dut_out`;
  - the next vector is applied on the same edge.
- **Wrap:** at idx = num_vec−1, `pass_cnt` increments (saturating). Then:
  - with `loop_en` latched 1, idx wraps to 0 and `dut_in` = vec[0];
  - otherwise the state goes to DONE with `busy` = 0 and `done` = 1, and `dut_in` holds the last vector.
- **Stop:** `stop` in RUN aborts to IDLE on the next edge. `busy` = 0, `done` stays 0, and counters and signature hold for readout. `stop` has priority over a same-cycle sample edge; that sample is discarded.
- **DONE:** holds all results until `start`. `start` in RUN is ignored.
- **Reset mid-run:** immediate return to IDLE with all outputs 0.

## Timing
- A vector is presented at edge k and sampled at edge k+S, where S = max(`settle`, 1). The period is S cycles per vector.
- `cap_valid` first rises S cycles after the start edge. It is never asserted in consecutive cycles unless S = 1.
- `done` rises on the edge after the final sample, i.e. the start edge + num_vec·S + 1.
- `err_cnt`, `pass_cnt` and `signature` are valid the cycle after the corresponding `cap_valid`.

## Test plan
- **Single pass, all match:** load 8 vectors with expected = golden c499 responses, mask all-1. Start with settle = 3, loop_en = 0, num_vec = 8. Required: 8 `cap_valid` pulses 3 cycles apart, `err_cnt` = 0, `pass_cnt` = 1, `done` at edge 25.
- **Masked mismatch:** corrupt exp[2] bit 5.
  - With mask bit 5 = 1: `err_cnt` = 1.
  - With mask bit 5 = 0: `err_cnt` = 0.
- **Loop mode:** num_vec = 3, settle = 1, loop_en = 1, run 30 cycles, then `stop`. Required:
  - `cap_idx` sequence 0, 1, 2, 0, 1, 2…;
  - `pass_cnt` = 10 when `stop` is asserted;
  - `busy` falls one edge after `stop`;
  - `done` = 0.
- **Boundaries:**
  - num_vec = 0 → `done` = 1 on the next edge, with no `cap_valid`.
  - settle = 0 behaves identically to settle = 1.
  - `ld_we` while `busy` leaves the table unchanged.
- **Async reset and signature:**
  - Assert `rst` mid-run between clock edges. Required: outputs go to 0 immediately, and a restart reproduces an identical signature.
  - Check `signature` against a reference MISR model computed over the 8 captured responses.
